// File: rtl/muldiv_sequencer_if.sv
// ============================================================================
// Module      : muldiv_sequencer_if
// Description : Request/result bundle between the execute stage and the
//               iterative multiply/divide sequencer.
//               master : core side (drives start/op/operands, reads results)
//               slave  : sequencer side
//               Signals: start, op[1:0], rs_val, rt_val   (core -> sequencer)
//                        busy, done, hi, lo, dbz          (sequencer -> core)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dbz;

    modport master (
        output start, op, rs_val, rt_val,
        input  busy, done, hi, lo, dbz
    );

    modport slave (
        input  start, op, rs_val, rt_val,
        output busy, done, hi, lo, dbz
    );
endinterface

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module      : muldiv_sequencer
// Description : Iterative mult/multu/div/divu unit owning the HI/LO pair.
//               Shift-add multiplier and restoring divider, one bit per cycle.
//               States IDLE -> RUN -> FIX -> DONE; divide-by-zero jumps from
//               acceptance straight to DONE.
// Ports       : clk, reset (sync, active high)
//               bus (slave) : start, op, rs_val, rt_val -> busy, done, hi,
//                             lo, dbz
// Options     : MULDIV_EARLY_OUT_EN - multiply stops iterating once the
//               remaining multiplier bits are all zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  wire logic         clk,
    input  wire logic         reset,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] acc_q,    acc_d;    // product upper half / remainder
    logic [WIDTH-1:0] mq_q,     mq_d;     // multiplier+product low / quotient
    logic [WIDTH-1:0] mcand_q,  mcand_d;  // multiplicand / divisor magnitude
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d; // negate product or quotient
    logic             neg_rem_q, neg_rem_d; // negate remainder
    logic [WIDTH-1:0] hi_q,     hi_d;
    logic [WIDTH-1:0] lo_q,     lo_d;
    logic             dbz_q,    dbz_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    // Operand magnitudes and sign bookkeeping at acceptance time
    logic             is_signed;
    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;
    logic             accept;

    assign is_signed = ~bus.op[0];
    assign rs_neg    = is_signed & bus.rs_val[WIDTH-1];
    assign rt_neg    = is_signed & bus.rt_val[WIDTH-1];
    assign rs_mag    = rs_neg ? (-bus.rs_val) : bus.rs_val;
    assign rt_mag    = rt_neg ? (-bus.rt_val) : bus.rt_val;
    assign accept    = bus.start & ((state_q == IDLE) | (state_q == DONE));

    // Datapath for one iteration
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic               trial_ok;
    logic [2*WIDTH-1:0] prod;

    assign mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : '0);
    assign rem_sh   = {acc_q, mq_q[WIDTH-1]};
    assign trial_ok = (rem_sh >= {1'b0, mcand_q});
    // With early-out some shifts are still pending; cnt_q is zero otherwise.
    assign prod     = {acc_q, mq_q} >> cnt_q;

`ifdef MULDIV_EARLY_OUT_EN
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] live_mask;
    assign ones      = '1;
    // Low cnt_d bits of mq_d are still unconsumed multiplier bits.
    assign live_mask = ones >> (CW'(WIDTH) - cnt_d);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        mcand_d   = mcand_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    is_div_d  = bus.op[1];
                    neg_res_d = rs_neg ^ rt_neg;
                    neg_rem_d = rs_neg;
                    cnt_d     = CW'(WIDTH);
                    acc_d     = '0;
                    if (bus.op[1]) begin
                        mq_d    = rs_mag;
                        mcand_d = rt_mag;
                    end else begin
                        mq_d    = rt_mag;
                        mcand_d = rs_mag;
                    end
                    if (bus.op[1] && (bus.rt_val == '0)) begin
                        hi_d    = bus.rs_val;
                        lo_d    = '1;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (is_div_q) begin
                    if (trial_ok) begin
                        acc_d = rem_sh[WIDTH-1:0] - mcand_q;
                        mq_d  = {mq_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = rem_sh[WIDTH-1:0];
                        mq_d  = {mq_q[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_d == '0) begin
                        state_d = FIX;
                    end
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
`ifdef MULDIV_EARLY_OUT_EN
                    if ((cnt_d == '0) || ((mq_d & live_mask) == '0)) begin
                        state_d = FIX;
                    end
`else
                    if (cnt_d == '0) begin
                        state_d = FIX;
                    end
`endif
                end
            end
            FIX: begin
                if (is_div_q) begin
                    lo_d = neg_res_q ? (-mq_q)  : mq_q;
                    hi_d = neg_rem_q ? (-acc_q) : acc_q;
                end else begin
                    {hi_d, lo_d} = neg_res_q ? (-prod) : prod;
                end
                cnt_d   = '0;
                dbz_d   = 1'b0;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            mcand_q   <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            mcand_q   <= mcand_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dbz_q     <= dbz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.dbz  = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Directed self-checking bench for muldiv_sequencer.
//               Expected latencies follow MULDIV_EARLY_OUT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;
    localparam int WIDTH = 32;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    muldiv_sequencer_if #(.WIDTH(WIDTH)) bus ();

    muldiv_sequencer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is seen by the next rising edge (E0).
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] ehi,
                          input logic [31:0] elo, input logic edbz);
        int n;
        int nbusy;
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = a;
        bus.rt_val = b;
        @(negedge clk);
        bus.start = 1'b0;
        n     = 1;
        nbusy = 0;
        while (!bus.done && n < 200) begin
            if (bus.busy) nbusy++;
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " busy cycles"}, 64'(nbusy), 64'(lat - 1));
        check({tag, " busy at done"}, 64'(bus.busy), 64'(0));
        check({tag, " hi"}, 64'(bus.hi), 64'(ehi));
        check({tag, " lo"}, 64'(bus.lo), 64'(elo));
        check({tag, " dbz"}, 64'(bus.dbz), 64'(edbz));
    endtask

    initial begin
        int ndone;
        int first;
        int pulse;

        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.rs_val = '0;
        bus.rt_val = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(bus.busy), 64'(0));
        check("reset done", 64'(bus.done), 64'(0));
        check("reset hi",   64'(bus.hi),   64'(0));
        check("reset lo",   64'(bus.lo),   64'(0));
        check("reset dbz",  64'(bus.dbz),  64'(0));
        reset = 1'b0;
        @(negedge clk);

        run_op("mult -3*5", 2'b00, 32'hFFFF_FFFD, 32'd5, EO ? 5 : 34,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        @(negedge clk);
        check("done one cycle", 64'(bus.done), 64'(0));

        run_op("divu 100/7", 2'b11, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0);
        // back-to-back from DONE
        run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 34,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        @(negedge clk);

        run_op("divu 5/0", 2'b11, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 1'b1);
        run_op("multu 2*3", 2'b01, 32'd2, 32'd3, EO ? 4 : 34, 32'd0, 32'd6, 1'b0);
        @(negedge clk);

        // Second start while busy must be dropped
        pulse      = EO ? 3 : 10;
        ndone      = 0;
        first      = 0;
        bus.start  = 1'b1;
        bus.op     = 2'b01;
        bus.rs_val = 32'd4;
        bus.rt_val = 32'd4;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            bus.start = (n == pulse);
            if (n == pulse) begin
                bus.rs_val = 32'd9;
                bus.rt_val = 32'd9;
            end
            if (bus.done) begin
                ndone++;
                if (first == 0) first = n;
            end
        end
        check("ignored start done count", 64'(ndone), 64'(1));
        check("ignored start latency", 64'(first), 64'(EO ? 5 : 34));
        check("ignored start lo", 64'(bus.lo), 64'(16));
        check("ignored start hi", 64'(bus.hi), 64'(0));

        // Reset in the middle of a divide
        bus.start  = 1'b1;
        bus.op     = 2'b10;
        bus.rs_val = 32'd1000;
        bus.rt_val = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid reset busy", 64'(bus.busy), 64'(0));
        check("mid reset done", 64'(bus.done), 64'(0));
        check("mid reset hi",   64'(bus.hi),   64'(0));
        check("mid reset lo",   64'(bus.lo),   64'(0));
        reset = 1'b0;
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("no done after reset", 64'(ndone), 64'(0));

        run_op("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 34,
               32'd0, 32'h8000_0000, 1'b0);
        run_op("multu 7*3", 2'b01, 32'd7, 32'd3, EO ? 4 : 34, 32'd0, 32'd21, 1'b0);
        run_op("multu 1*0", 2'b01, 32'd1, 32'd0, EO ? 3 : 34, 32'd0, 32'd0, 1'b0);
        run_op("mult -1*-1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, EO ? 3 : 34,
               32'd0, 32'd1, 1'b0);
        run_op("multu max*max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, EO ? 34 : 34,
               32'hFFFF_FFFE, 32'd1, 1'b0);
        run_op("div 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 34,
               32'd1, 32'hFFFF_FFFD, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide sequencer for the MIPS execute stage. It handles `mult`, `multu`, `div` and `divu` (funct 0x18–0x1B), which the single-cycle ALU does not implement. It runs a shift-add multiplier or a restoring divider over several cycles and owns the HI/LO register pair. The core stalls on `busy` and captures results on `done`.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits.
- `clk` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: synchronous, active-high.
- `start` input, 1 bit: request a new operation. Sampled only when `busy`=0.
- `op` input, 2 bits: operation select, equal to funct[1:0]. 00 mult, 01 multu, 10 div, 11 divu.
- `rs_val` input, `WIDTH` bits: multiplicand, or dividend.
- `rt_val` input, `WIDTH` bits: multiplier, or divisor.
- `busy` output, 1 bit: high in RUN and FIX.
- `done` output, 1 bit: one-cycle pulse in DONE.
- `hi` output, `WIDTH` bits: product upper half, or remainder.
- `lo` output, `WIDTH` bits: product lower half, or quotient.
- `dbz` output, 1 bit: the last completed division had a zero divisor.

## Operation
- States:
  - IDLE, RUN, FIX and DONE.
  - Reset forces IDLE and clears `hi`, `lo`, `dbz`, the internal accumulators and the iteration counter.
  - Reset values of outputs: `busy`=0, `done`=0, `hi`=0, `lo`=0, `dbz`=0.
- Operation start:
  - `start` is accepted in IDLE or DONE, i.e. whenever `busy`=0.
  - At acceptance the block latches `op` and the operand magnitudes. Signed ops take absolute values; unsigned ops use the raw values.
  - It also latches the result-sign flags, loads the counter with `WIDTH`, and moves to RUN.
- Divide by zero:
  - Applies when `start` is accepted with op[1]=1 and `rt_val`=0.
  - The block goes straight to DONE.
  - Results: `hi`=`rs_val`, `lo` = all ones, `dbz`=1.
- RUN, multiply:
  - Each cycle, if the multiplier LSB is 1, add the multiplicand to the upper accumulator.
  - Then shift the {accumulator, multiplier} pair right by 1 and decrement the counter.
- RUN, divide:
  - Each cycle, shift the {remainder, quotient} pair left by 1.
  - Trial-subtract the divisor. If the result is non-negative, keep it and set the quotient LSB to 1.
  - Decrement the counter.
- Leaving RUN: when the counter reaches 0, go to FIX.
- FIX (one cycle):
  - Signed product: negate the 2·`WIDTH` result if the operand signs differ.
  - Signed quotient: negate if the operand signs differ.
  - Signed remainder: takes the sign of the dividend.
  - Write `hi`/`lo`, clear `dbz`, go to DONE.
- DONE (one cycle): `done`=1. Go to IDLE, or to RUN if `start` is accepted in this cycle.
- Overflow case: div of 0x80000000 by 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0. No error flag is raised.
- `hi`, `lo` and `dbz` hold their values until the next write at FIX or divide-by-zero, or until reset.
- `start` while `busy`=1 is ignored. It is not queued.

## Timing
- `start` is accepted at clock edge E0.
- Normal multiply and divide:
  - RUN occupies edges E1..E`WIDTH`.
  - FIX writes results at edge E`WIDTH`+1.
  - `done` is high in the following cycle, so the latency is `WIDTH`+2 cycles (34 for the default width).
- Divide by zero: results written and `done` high one cycle after E0.
- Back-to-back throughput: `start` asserted during DONE enters RUN at the next edge.
- Reset asserted mid-operation: next edge gives IDLE with all outputs 0. No `done` pulse occurs.
- `busy` is a registered function of the state only. It has no combinational path from `start`.

## Configuration
- `MULDIV_EARLY_OUT_EN`
  - Defined:
    - Multiply leaves RUN after any iteration where the shifted multiplier register becomes zero, with a minimum of 1 iteration.
    - Before FIX, the remaining shift is applied to the accumulator in one step so the results are identical.
    - Latency is (index of the highest set multiplier-magnitude bit + 1) + 2 cycles.
    - Multiplier = 0 gives latency 3.
  - Undefined: every multiply takes exactly `WIDTH` RUN cycles.
  - Division timing is unaffected either way.

## Test plan
- mult, `rs_val`=0xFFFFFFFD (−3), `rt_val`=5, macro off -> `done` at cycle 34, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1, `busy` high cycles 1–33.
- divu 100 / 7 -> `lo`=14, `hi`=2, `dbz`=0. Then div 0xFFFFFFF9 (−7) / 2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- divu 5 / 0 -> `done` at cycle 1, `hi`=5, `lo`=0xFFFFFFFF, `dbz`=1. A following multu 2·3 clears `dbz`: `lo`=6, `hi`=0.
- Second `start` (multu 9·9) pulsed at cycle 10 of a running multu 4·4 -> ignored. `lo`=16, and no second `done`.
- Reset at cycle 12 of a div -> next cycle `busy`=0, `hi`=`lo`=0, no `done`. A new div 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- `MULDIV_EARLY_OUT_EN` defined, multu 7·3 -> RUN 2 cycles, `done` at cycle 4, `lo`=21, `hi`=0. Multu 1·0 -> `done` at cycle 3, `lo`=0.
